// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its line front end.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_WAITIDLE
  } state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  localparam int TIMEOUT_W = 21;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronises the PS/2 clock and data pads into the clock domain and flags
// ps2_clk falling edges with a one-cycle pulse.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [SYNC_STAGES-1:0] clk_meta_q, clk_meta_d;
  logic [SYNC_STAGES-1:0] data_meta_q, data_meta_d;
  logic                   clk_prev_q, clk_prev_d;

  // NOTE: every signal assigned here is a pure function of the current inputs, so no latch is inferred.
  always_comb begin
    clk_meta_d  = {clk_meta_q[SYNC_STAGES-2:0], clk_in};
    data_meta_d = {data_meta_q[SYNC_STAGES-2:0], data_in};
    clk_prev_d  = clk_meta_q[SYNC_STAGES-1];
  end

  // Idle bus level is high, so resetting to 1 avoids a false fall after reset.
  // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta_q  <= '1;
      data_meta_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_meta_q  <= clk_meta_d;
      data_meta_q <= data_meta_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  assign clk_sync  = clk_meta_q[SYNC_STAGES-1];
  assign data_sync = data_meta_q[SYNC_STAGES-1];
  assign clk_fall  = clk_prev_q & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts one
// command byte out on device-generated clocks and reports ACK, NACK or timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int                   INH_W    = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0]     INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  // Decided one cycle early so the registered pulse lands TIMEOUT_CYCLES cycles after REQ.
  localparam logic [TIMEOUT_W-1:0] TO_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 2);

  logic clk_sync, data_sync, clk_fall;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clock    (clock),
    .reset    (reset),
    .clk_in   (ps2_clk_in),
    .data_in  (ps2_data_in),
    .clk_sync (clk_sync),
    .data_sync(data_sync),
    .clk_fall (clk_fall)
  );

  state_e               state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0]     inh_cnt_q, inh_cnt_d;
  logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ok_q, ok_d;
  logic                 clk_oe_q, clk_oe_d;
  logic                 data_oe_q, data_oe_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    ok_d      = ok_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid && ready_q) begin
          state_d   = ST_INHIBIT;
          shift_d   = tx_data;
          par_d     = odd_parity(tx_data);
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          state_d   = ST_REQ;
          data_oe_d = 1'b1;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      ST_REQ: begin
        state_d   = ST_SHIFT;
        clk_oe_d  = 1'b0;
        bit_cnt_d = '0;
        to_cnt_d  = '0;
      end
      ST_SHIFT: begin
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            data_oe_d = ~shift_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            data_oe_d = ~par_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          ok_d      = ~data_sync;
          state_d   = ST_WAITIDLE;
        end
      end
      ST_WAITIDLE: begin
        if (clk_sync && data_sync) begin
          state_d = ST_IDLE;
          done_d  = ok_q;
          err_d   = ~ok_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The timeout overrides whatever the frame logic decided this cycle.
    if (state_q inside {ST_SHIFT, ST_ACK, ST_WAITIDLE}) begin
      to_cnt_d = to_cnt_q + 1'b1;
      if (to_cnt_q == TO_LAST) begin
        state_d   = ST_IDLE;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b1;
      end
    end

    ready_d = (state_d == ST_IDLE) && !done_d && !err_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      ok_q      <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      ok_q      <= ok_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  assign tx_ready    = ready_q;
  assign busy        = ~ready_q;
  assign tx_done     = done_q;
  assign tx_error    = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
